// File: rtl/t07_simon_pkg.sv
// Shared Simon-Says definitions, used by the display sequencer and the press
// detector.
//   simon_state_t : press-detector state, D1..D5 (even codes) and I1..I5 (odd codes)
//   PLAY_SIMON    : playing_state_in value that selects the Simon module
//   BTN_*         : one-hot button codes
//   COL_*         : colour encoding used on the sequence bus
//   seq_fsm_t     : display sequencer FSM states (ECHO is only reached in echo builds)
package t07_simon_pkg;

  typedef enum logic [3:0] {
    D1 = 4'd0, I1, D2, I2, D3, I3, D4, I4, D5, I5
  } simon_state_t;

  localparam logic [2:0] PLAY_SIMON = 3'd4;

  localparam logic [5:0] BTN_UP    = 6'b000010;
  localparam logic [5:0] BTN_RIGHT = 6'b000100;
  localparam logic [5:0] BTN_DOWN  = 6'b001000;
  localparam logic [5:0] BTN_LEFT  = 6'b010000;

  localparam logic [1:0] COL_BLUE   = 2'd0;
  localparam logic [1:0] COL_YELLOW = 2'd1;
  localparam logic [1:0] COL_GREEN  = 2'd2;
  localparam logic [1:0] COL_RED    = 2'd3;

  typedef enum logic [2:0] {IDLE, ON, OFF, GAP, ECHO} seq_fsm_t;

endpackage

// File: rtl/t07_flash_timer.sv
// Phase timer for the flash sequencer.
//   clk, nrst : clock, async active-low reset
//   clr       : synchronous clear back to 0
//   limit     : terminal count (phase length - 1)
//   tc        : counter currently equals limit
// The counter holds at limit rather than wrapping.
module t07_flash_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == limit);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (!tc)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/t07_simon_display_sequencer.sv
// Simon-Says flash sequencer: in display state Dn plays colours 0..n-1 as timed
// ON/OFF flashes, then a dark gap, and repeats until the press detector moves on.
//   clk, nrst           : clock, async active-low reset
//   playing_state_in    : selected module (display only at PLAY_SIMON)
//   activate_rand       : new-game pulse, forces dark/idle
//   simon_cleared       : module solved, forces dark/idle
//   simon_state_in      : press-detector state (even = display, odd = input)
//   simon_sequence_bus  : colour i in bits [2i+1:2i]
//   strobe, button      : button press (echo builds only)
//   light_en/light_color: lit colour (colour 0 when dark)
//   flash_idx           : index of current / most recent colour
//   seq_done            : 1-cycle pulse at the end of the last OFF of a pass
// Optional: define SIMON_PRESS_ECHO_EN to echo button presses in input states.
module t07_simon_display_sequencer
  import t07_simon_pkg::*;
#(
  parameter int ON_CYCLES  = 5000000,
  parameter int OFF_CYCLES = 2500000,
  parameter int GAP_CYCLES = 10000000,
  parameter int CNT_W      = 24
`ifdef SIMON_PRESS_ECHO_EN
  , parameter int ECHO_CYCLES = 2500000
`endif
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [2:0] playing_state_in,
  input  logic       activate_rand,
  input  logic       simon_cleared,
  input  logic [3:0] simon_state_in,
  input  logic [9:0] simon_sequence_bus,
  input  logic       strobe,
  input  logic [5:0] button,
  output logic       light_en,
  output logic [1:0] light_color,
  output logic [2:0] flash_idx,
  output logic       seq_done
);

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES - 1);

  seq_fsm_t         state, state_d;
  logic [2:0]       idx, idx_d;
  logic [3:0]       prev_state;
  logic [2:0]       stage;
  logic             disp_en, restart, live, tc, tmr_clr;
  logic [CNT_W-1:0] tmr_lim;
  logic [1:0]       cur_color;
  logic             light_en_d, seq_done_d;
  logic [1:0]       light_color_d;
  logic [2:0]       flash_idx_d;

  assign disp_en = (playing_state_in == PLAY_SIMON) && !simon_cleared && !activate_rand &&
                   !simon_state_in[0] && (simon_state_in <= 4'd8);
  assign stage   = simon_state_in[3:1];
  assign restart = disp_en && ((state == IDLE) || (simon_state_in != prev_state));
  // Outputs are blanked on the cycle a restart/abort is taken so the light
  // drops immediately rather than one cycle later.
  assign live      = disp_en && !restart;
  assign cur_color = simon_sequence_bus[{idx, 1'b0} +: 2];

`ifdef SIMON_PRESS_ECHO_EN
  localparam logic [CNT_W-1:0] ECHO_LIM = CNT_W'(ECHO_CYCLES - 1);
  logic       echo_ok, echo_hit, echo_start;
  logic [1:0] btn_color, echo_color;

  assign echo_ok    = (playing_state_in == PLAY_SIMON) && !simon_cleared && !activate_rand &&
                      simon_state_in[0] && (simon_state_in <= 4'd9);
  assign echo_start = echo_ok && echo_hit && ((state == IDLE) || (state == ECHO));

  always_comb begin
    btn_color = COL_BLUE;
    echo_hit  = strobe;
    case (button)
      BTN_UP:    btn_color = COL_BLUE;
      BTN_RIGHT: btn_color = COL_YELLOW;
      BTN_DOWN:  btn_color = COL_GREEN;
      BTN_LEFT:  btn_color = COL_RED;
      default:   echo_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)           echo_color <= COL_BLUE;
    else if (echo_start) echo_color <= btn_color;
  end
`else
  logic unused_echo;
  assign unused_echo = ^{strobe, button};
`endif

  t07_flash_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (tmr_clr),
    .limit (tmr_lim),
    .tc    (tc)
  );

  always_comb begin
    tmr_lim = '0;
    case (state)
      ON:      tmr_lim = ON_LIM;
      OFF:     tmr_lim = OFF_LIM;
      GAP:     tmr_lim = GAP_LIM;
`ifdef SIMON_PRESS_ECHO_EN
      ECHO:    tmr_lim = ECHO_LIM;
`endif
      default: tmr_lim = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      idx        <= '0;
      prev_state <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      prev_state <= simon_state_in;
    end
  end

  // next state
  always_comb begin
    state_d = state;
    idx_d   = idx;
    tmr_clr = 1'b0;
    if (!disp_en) begin
      state_d = IDLE;
      tmr_clr = 1'b1;
`ifdef SIMON_PRESS_ECHO_EN
      if (echo_start) begin
        state_d = ECHO;
      end else if ((state == ECHO) && echo_ok && !tc) begin
        state_d = ECHO;
        tmr_clr = 1'b0;
      end
`endif
    end else if (restart) begin
      state_d = ON;
      idx_d   = '0;
      tmr_clr = 1'b1;
    end else begin
      case (state)
        ON: if (tc) begin
          state_d = OFF;
          tmr_clr = 1'b1;
        end
        OFF: if (tc) begin
          tmr_clr = 1'b1;
          if (idx == stage) begin
            state_d = GAP;
            idx_d   = '0;
          end else begin
            state_d = ON;
            idx_d   = idx + 3'd1;
          end
        end
        GAP: if (tc) begin
          state_d = ON;
          idx_d   = '0;
          tmr_clr = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // outputs (registered below)
  always_comb begin
    light_en_d    = 1'b0;
    light_color_d = COL_BLUE;
    flash_idx_d   = '0;
    seq_done_d    = 1'b0;
    if (live) begin
      flash_idx_d = idx;
      if (state == ON) begin
        light_en_d    = 1'b1;
        light_color_d = cur_color;
      end
      if ((state == OFF) && tc && (idx == stage)) seq_done_d = 1'b1;
    end
`ifdef SIMON_PRESS_ECHO_EN
    if ((state == ECHO) && echo_ok && !echo_start) begin
      light_en_d    = 1'b1;
      light_color_d = echo_color;
      flash_idx_d   = idx;
    end
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      light_en    <= 1'b0;
      light_color <= '0;
      flash_idx   <= '0;
      seq_done    <= 1'b0;
    end else begin
      light_en    <= light_en_d;
      light_color <= light_color_d;
      flash_idx   <= flash_idx_d;
      seq_done    <= seq_done_d;
    end
  end

endmodule

// File: tb/tb_t07_simon_display_sequencer.sv
// Self-checking bench for t07_simon_display_sequencer (ON=4, OFF=2, GAP=6).
// Expected per-cycle outputs are queued whenever the stimulus changes and
// popped/compared on each falling clock edge.
module tb_t07_simon_display_sequencer;
  import t07_simon_pkg::*;

  logic       clk = 1'b0;
  logic       nrst;
  logic [2:0] playing_state_in;
  logic       activate_rand, simon_cleared, strobe;
  logic [3:0] simon_state_in;
  logic [9:0] seq;
  logic [5:0] button;
  logic       light_en, seq_done;
  logic [1:0] light_color;
  logic [2:0] flash_idx;

  t07_simon_display_sequencer #(
    .ON_CYCLES(4), .OFF_CYCLES(2), .GAP_CYCLES(6), .CNT_W(4)
  ) dut (
    .clk                (clk),
    .nrst               (nrst),
    .playing_state_in   (playing_state_in),
    .activate_rand      (activate_rand),
    .simon_cleared      (simon_cleared),
    .simon_state_in     (simon_state_in),
    .simon_sequence_bus (seq),
    .strobe             (strobe),
    .button             (button),
    .light_en           (light_en),
    .light_color        (light_color),
    .flash_idx          (flash_idx),
    .seq_done           (seq_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       le;
    logic [1:0] col;
    logic [2:0] idx;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, got, want);
  endtask

  task automatic push(input logic le, input logic [1:0] col, input int i, input logic done);
    exp_t e;
    e.le = le; e.col = col; e.idx = 3'(i); e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic push_dark(input int n);
    repeat (n) push(1'b0, 2'd0, 0, 1'b0);
  endtask

  task automatic push_lit(input int i, input int n);
    repeat (n) push(1'b1, seq[2*i +: 2], i, 1'b0);
  endtask

  // one full pass for a display stage: each colour 4 lit + 2 dark
  // (seq_done on the last dark of the last colour), then 6 dark
  task automatic push_pass(input int stage);
    for (int i = 0; i <= stage; i++) begin
      push_lit(i, 4);
      push(1'b0, 2'd0, i, 1'b0);
      push(1'b0, 2'd0, i, i == stage);
    end
    push_dark(6);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      chk("light_en", light_en, e.le);
      chk("light_color", light_color, e.col);
      chk("seq_done", seq_done, e.done);
      if (e.le) chk("flash_idx", flash_idx, e.idx);
    end
  endtask

  initial begin
    nrst = 1'b1; playing_state_in = 3'd0; activate_rand = 1'b0; simon_cleared = 1'b0;
    simon_state_in = 4'd0; seq = 10'b11_10_01_00_11; strobe = 1'b0; button = 6'd0;
    #2 nrst = 1'b0;
    #1;
    chk("rst_light_en", light_en, 0);
    chk("rst_light_color", light_color, 0);
    chk("rst_flash_idx", flash_idx, 0);
    chk("rst_seq_done", seq_done, 0);
    @(negedge clk); #1 nrst = 1'b1;

    // D3: colours 3,0,1, two full passes
    playing_state_in = PLAY_SIMON; simon_state_in = 4'd4;
    push_dark(1); push_pass(2); push_pass(2);
    drain();

    // D1, then D2 in the middle of the second flash
    #1 simon_state_in = 4'd0;
    push_dark(1); push_pass(0); push_lit(0, 2);
    drain();
    #1 simon_state_in = 4'd2;
    push_dark(1); push_pass(1);
    drain();

    // D3 -> I3 mid-flash: dark next cycle, stays dark despite UP presses
    #1 simon_state_in = 4'd4;
    push_dark(1); push_lit(0, 3);
    drain();
    #1 simon_state_in = 4'd5; strobe = 1'b1; button = BTN_UP;
    push_dark(1); drain();
    #1 strobe = 1'b0;
    push_dark(3); drain();
    #1 strobe = 1'b1;
    push_dark(1); drain();
    #1 strobe = 1'b0; button = 6'd0;
    push_dark(3); drain();

    // activate_rand during ON, then resume from idx 0
    #1 simon_state_in = 4'd4;
    push_dark(1); push_lit(0, 4); push_dark(2); push_lit(1, 2);
    drain();
    #1 activate_rand = 1'b1;
    push_dark(3); drain();
    #1 activate_rand = 1'b0;
    push_dark(1); push_pass(2); push_lit(0, 2);
    drain();

    // simon_cleared during ON, then resume from idx 0
    #1 simon_cleared = 1'b1;
    push_dark(3); drain();
    #1 simon_cleared = 1'b0;
    push_dark(1); push_lit(0, 4);
    drain();

    // other module selected, then an invalid state code
    #1 playing_state_in = 3'd2;
    push_dark(4); drain();
    #1 playing_state_in = PLAY_SIMON; simon_state_in = 4'd12;
    push_dark(4); drain();

    // async reset in the middle of a flash
    #1 simon_state_in = 4'd4;
    push_dark(1); push_lit(0, 2);
    drain();
    #2 nrst = 1'b0;
    #1;
    chk("async_light_en", light_en, 0);
    chk("async_light_color", light_color, 0);
    chk("async_flash_idx", flash_idx, 0);
    chk("async_seq_done", seq_done, 0);
    @(negedge clk); #1 nrst = 1'b1;
    push_dark(1); push_pass(2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
